// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
// Purpose : Bundles the serial input line and the received-byte outputs of
//           the UART receiver into one interface.
// Signals : rx        - serial line, idle high, 8N1, LSB first
//           rx_done   - one-cycle pulse, rx_data holds a new valid byte
//           rx_data   - last correctly framed byte, held between frames
//           frame_err - one-cycle pulse, stop bit sampled low
//           busy      - receiver is inside a frame (not IDLE)
// Modports: master - drives rx, observes receiver outputs (line side / bench)
//           slave  - the receiver itself
// ----------------------------------------------------------------------------
interface uart_rx_if;
  logic       rx;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  rx_done,
    input  rx_data,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  rx,
    output rx_done,
    output rx_data,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// Purpose : 8N1 UART receiver. The serial line is synchronized, a falling
//           edge starts a frame, the start bit is re-checked at mid-bit and
//           each data/stop bit is sampled one bit period later.
// Params  : CLKS_PER_BIT - clk cycles per serial bit (>= 4)
// Ports   : clk   - system clock, rising edge
//           n_rst - asynchronous active-low reset
//           bus   - uart_rx_if.slave (rx in; rx_done, rx_data, frame_err,
//                   busy out)
// ----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       n_rst,
  uart_rx_if.slave   bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_next_s;

  logic          rx_meta_r;
  logic          rx_sync_r;     // second synchronizer flop
  logic          rx_sync_d_r;   // one-cycle-delayed copy for edge detect
  logic          start_edge_s;

  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic [7:0]    rx_data_r;
  logic          rx_done_r;
  logic          frame_err_r;

  logic          cnt_clr_s;
  logic          bit_clr_s;
  logic          bit_inc_s;
  logic          shift_en_s;
  logic          done_set_s;
  logic          ferr_set_s;

  // Two-flop synchronizer plus delayed copy; all idle high so reset never
  // looks like a start edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta_r   <= 1'b1;
      rx_sync_r   <= 1'b1;
      rx_sync_d_r <= 1'b1;
    end else begin
      rx_meta_r   <= bus.rx;
      rx_sync_r   <= rx_meta_r;
      rx_sync_d_r <= rx_sync_r;
    end
  end

  // Only a true high-to-low transition starts a frame, so a line held low
  // (break) cannot re-trigger.
  assign start_edge_s = rx_sync_d_r & ~rx_sync_r;

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next_s = state_r;
    cnt_clr_s    = 1'b0;
    bit_clr_s    = 1'b0;
    bit_inc_s    = 1'b0;
    shift_en_s   = 1'b0;
    done_set_s   = 1'b0;
    ferr_set_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // Counter held at zero so every exit from IDLE starts counting at 0.
        cnt_clr_s = 1'b1;
        if (start_edge_s) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_M1) begin
          cnt_clr_s = 1'b1;
          if (!rx_sync_r) begin
            bit_clr_s    = 1'b1;
            state_next_s = DATA;
          end else begin
            // Line went back high before mid start bit: glitch, drop it.
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = START;
        end
      end
      DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_clr_s  = 1'b1;
          shift_en_s = 1'b1;
          if (bit_idx_r == 3'd7) begin
            state_next_s = STOP;
          end else begin
            bit_inc_s    = 1'b1;
            state_next_s = DATA;
          end
        end else begin
          state_next_s = DATA;
        end
      end
      STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_clr_s    = 1'b1;
          state_next_s = IDLE;
          if (rx_sync_r) begin
            done_set_s = 1'b1;
          end else begin
            ferr_set_s = 1'b1;
          end
        end else begin
          state_next_s = STOP;
        end
      end
      default: begin
        cnt_clr_s    = 1'b1;
        state_next_s = IDLE;
      end
    endcase
  end

  // Bit-period counter, bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      if (cnt_clr_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
      if (bit_clr_s) begin
        bit_idx_r <= 3'd0;
      end else if (bit_inc_s) begin
        bit_idx_r <= bit_idx_r + 3'd1;
      end
      if (shift_en_s) begin
        shift_r[bit_idx_r] <= rx_sync_r;
      end
    end
  end

  // Registered result outputs: byte and pulses appear the cycle after the
  // stop sample; a framing error leaves the held byte untouched.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data_r   <= 8'h00;
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      rx_done_r   <= done_set_s;
      frame_err_r <= ferr_set_s;
      if (done_set_s) begin
        rx_data_r <= shift_r;
      end
    end
  end

  assign bus.rx_done   = rx_done_r;
  assign bus.rx_data   = rx_data_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = (state_r != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Purpose : Directed self-checking bench for uart_rx at CLKS_PER_BIT = 16.
//           Stimulus pushes the expected pulse (done/frame error + held byte)
//           into a scoreboard queue; a negedge monitor pops and compares on
//           every rx_done / frame_err pulse.
// ----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB = 16;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
  } ev_t;

  logic      clk;
  logic      n_rst;
  uart_rx_if bus ();

  ev_t sb_q[$];
  ev_t mon_e;

  int checks;
  int fails;
  int cyc;
  int done_cnt;
  int ferr_cnt;
  int last_done_cyc;
  int prev_done_cyc;
  int fall_cyc;
  int tmp_cnt;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.rx_done && bus.frame_err) begin
        chk(1'b0, "done_and_ferr_together", 1, 0);
      end
      if (bus.rx_done || bus.frame_err) begin
        if (sb_q.size() == 0) begin
          chk(1'b0, "unexpected_pulse(done*2+ferr)",
              {30'd0, bus.rx_done, bus.frame_err}, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk(bus.frame_err == mon_e.is_ferr, "pulse_kind_is_ferr",
              int'(bus.frame_err), int'(mon_e.is_ferr));
          chk(bus.rx_data == mon_e.data, "rx_data_at_pulse",
              int'(bus.rx_data), int'(mon_e.data));
        end
        if (bus.rx_done) begin
          done_cnt++;
          prev_done_cyc = last_done_cyc;
          last_done_cyc = cyc;
        end
        if (bus.frame_err) ferr_cnt++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    bus.rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      idle(CPB);
    end
    bus.rx = stop_bit;
    idle(CPB);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
    chk(sb_q.size() == 0, name, sb_q.size(), 0);
    idle(4);
    chk(bus.busy == 1'b0, "busy_after_frame", int'(bus.busy), 0);
  endtask

  initial begin
    checks = 0; fails = 0; cyc = 0;
    done_cnt = 0; ferr_cnt = 0; last_done_cyc = 0; prev_done_cyc = 0;
    bus.rx = 1'b1;
    n_rst  = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    chk(bus.rx_done == 1'b0,   "reset_rx_done",   int'(bus.rx_done), 0);
    chk(bus.frame_err == 1'b0, "reset_frame_err", int'(bus.frame_err), 0);
    chk(bus.busy == 1'b0,      "reset_busy",      int'(bus.busy), 0);
    chk(bus.rx_data == 8'h00,  "reset_rx_data",   int'(bus.rx_data), 0);
    idle(3);
    n_rst = 1'b1;
    idle(10);

    // Valid 0x55 plus latency from the start-bit falling edge. The monitor
    // samples half a cycle after the rising edge, so 154.5 clk shows as 155.
    sb_q.push_back('{is_ferr: 1'b0, data: 8'h55});
    fall_cyc = cyc;
    send_frame(8'h55, 1'b1);
    drain("drain_0x55");
    chk(last_done_cyc - fall_cyc inside {[154:156]}, "latency_0x55",
        last_done_cyc - fall_cyc, 155);
    chk(ferr_cnt == 0, "no_ferr_0x55", ferr_cnt, 0);

    // Short low glitch: START aborts silently.
    tmp_cnt = done_cnt;
    bus.rx = 1'b0;
    idle(4);
    bus.rx = 1'b1;
    chk(bus.busy == 1'b1, "glitch_busy_high", int'(bus.busy), 1);
    idle(20);
    chk(bus.busy == 1'b0, "glitch_busy_low", int'(bus.busy), 0);
    chk(done_cnt == tmp_cnt && ferr_cnt == 0, "glitch_no_pulse",
        done_cnt + ferr_cnt, tmp_cnt);
    chk(bus.rx_data == 8'h55, "glitch_rx_data_held", int'(bus.rx_data), 8'h55);

    // 0xA3 with stop bit low: frame error, held byte stays 0x55.
    sb_q.push_back('{is_ferr: 1'b1, data: 8'h55});
    send_frame(8'hA3, 1'b0);
    bus.rx = 1'b1;
    drain("drain_ferr");
    chk(bus.rx_data == 8'h55, "ferr_rx_data_held", int'(bus.rx_data), 8'h55);
    idle(16);

    // Back-to-back 0x12, 0x34 with no idle bit.
    sb_q.push_back('{is_ferr: 1'b0, data: 8'h12});
    sb_q.push_back('{is_ferr: 1'b0, data: 8'h34});
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    drain("drain_b2b");
    chk(last_done_cyc - prev_done_cyc inside {[159:161]}, "b2b_spacing",
        last_done_cyc - prev_done_cyc, 160);

    // Reset in the middle of bit 3 of 0xFF.
    bus.rx = 1'b0;
    idle(CPB);
    bus.rx = 1'b1;
    idle(3 * CPB + CPB / 2);
    n_rst = 1'b0;
    #1;
    chk(bus.rx_done == 1'b0,   "midrst_rx_done",   int'(bus.rx_done), 0);
    chk(bus.frame_err == 1'b0, "midrst_frame_err", int'(bus.frame_err), 0);
    chk(bus.busy == 1'b0,      "midrst_busy",      int'(bus.busy), 0);
    chk(bus.rx_data == 8'h00,  "midrst_rx_data",   int'(bus.rx_data), 0);
    idle(5);
    n_rst = 1'b1;
    idle(20);
    sb_q.push_back('{is_ferr: 1'b0, data: 8'hC3});
    send_frame(8'hC3, 1'b1);
    drain("drain_0xC3");

    // Break: 40 bit periods low gives exactly one frame error, then quiet.
    tmp_cnt = ferr_cnt;
    sb_q.push_back('{is_ferr: 1'b1, data: 8'hC3});
    bus.rx = 1'b0;
    idle(40 * CPB);
    chk(ferr_cnt - tmp_cnt == 1, "break_one_ferr", ferr_cnt - tmp_cnt, 1);
    chk(bus.busy == 1'b0, "break_busy_low", int'(bus.busy), 0);
    chk(sb_q.size() == 0, "break_sb_empty", sb_q.size(), 0);
    bus.rx = 1'b1;
    idle(20);
    chk(bus.busy == 1'b0, "break_release_idle", int'(bus.busy), 0);
    sb_q.push_back('{is_ferr: 1'b0, data: 8'h5A});
    send_frame(8'h5A, 1'b1);
    drain("drain_after_break");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 434 (50 MHz / 115200 baud), clk cycles per serial bit; legal range >= 4.
REQ-002 SHALL provide port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL provide port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 SHALL provide port rx_done  output  1  one-cycle pulse, valid byte on rx_data.
REQ-006 SHALL provide port rx_data  output  8  last correctly framed byte; held between frames.
REQ-007 SHALL provide port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-008 SHALL provide port busy  output  1  high in any state other than IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer, both flops reset to 1; rx_s denotes the second flop output.
REQ-010 SHALL keep rx_s_d, a one-cycle-delayed copy of rx_s reset to 1; start detect = rx_s_d==1 && rx_s==0 (falling edge only).
REQ-011 SHALL implement states IDLE, START, DATA, STOP; reset state IDLE.
REQ-012 SHALL use a bit-period counter of width clog2(CLKS_PER_BIT), cleared on every state entry.
REQ-013 IDLE: on start detect, clear counter and go to START; otherwise stay.
REQ-014 START: when counter == CLKS_PER_BIT/2 - 1 (integer division), sample rx_s; if 0, clear counter, clear bit index, go to DATA; if 1 (glitch), go to IDLE with no output pulse.
REQ-015 DATA: when counter == CLKS_PER_BIT - 1, shift rx_s into an 8-bit shift register at bit position bit_idx (LSB first) and clear counter; after the sample with bit_idx == 7, go to STOP, else increment bit_idx.
REQ-016 STOP: when counter == CLKS_PER_BIT - 1, sample rx_s and go to IDLE.
REQ-017 If the STOP sample is 1, SHALL load rx_data from the shift register and assert rx_done for exactly one cycle, both in the cycle after the sample.
REQ-018 If the STOP sample is 0, SHALL assert frame_err for exactly one cycle in the cycle after the sample and leave rx_data unchanged; rx_done stays 0.
REQ-019 rx_done and frame_err SHALL never be high in the same cycle.
REQ-020 A new start edge arriving directly after a valid stop bit SHALL be accepted without an extra idle bit (back-to-back frames).
REQ-021 After a frame error with rx held low, SHALL NOT re-trigger until rx returns high and falls again.
REQ-022 Latency: rx_done rises 2 (synchronizer) + 0.5 + 9 bit periods (+/-1 clk) after the rx falling edge of the start bit.
REQ-023 busy SHALL be combinational from state: 0 in IDLE, 1 otherwise.

Reset
REQ-024 On n_rst low, SHALL immediately force: state IDLE, counter 0, bit_idx 0, shift register 0x00, rx_data 0x00, rx_done 0, frame_err 0, busy 0, synchronizer flops and rx_s_d 1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release, the next full frame SHALL be received correctly.

Verification (CLKS_PER_BIT = 16)
REQ-026 Send 0x55 with valid stop -> exactly one rx_done pulse, rx_data = 0x55, frame_err never high, busy returns to 0.
REQ-027 Drive rx low for 4 clk, then high -> START aborts, no rx_done/frame_err, busy high then 0, rx_data unchanged.
REQ-028 After 0x55, send 0xA3 with stop bit 0 -> one frame_err pulse, no rx_done, rx_data stays 0x55.
REQ-029 Send 0x12 then 0x34 with no idle gap -> two rx_done pulses 160 clk apart (+/-1), rx_data 0x12 then 0x34.
REQ-030 Assert n_rst during bit 3 of 0xFF -> all outputs 0 immediately; after release send 0xC3 -> one rx_done, rx_data = 0xC3.
REQ-031 Hold rx low for 40 bit periods (break) -> exactly one frame_err pulse, no further activity until rx rises and a new frame starts.
